// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//   Parametrised 2-read / 1-write register file for the RISC-V pipeline,
//   sitting between decode (read addresses) and writeback (write port).
//   After reset the array is swept to zero one entry per cycle (INIT); only
//   then does `ready` rise and normal accesses get accepted (RUN).
//   Reads are registered (latency 1) and flagged by a one-cycle `rd_valid`.
//   A same-cycle write can optionally be forwarded to a matching read.
//
// Parameters
//   XLEN     data width in bits
//   NREG     number of registers (2 .. 2**AW)
//   AW       address width
//   ZERO_REG 1 = register 0 reads as zero and ignores writes
//   BYPASS   1 = same-cycle write data forwarded to a matching read
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous reset, active-low
//   rd_en     in   read request (both ports)
//   rs1_addr  in   read port 1 address
//   rs2_addr  in   read port 2 address
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_data   in   write data
//   rs1_data  out  registered read data, port 1
//   rs2_data  out  registered read data, port 2
//   rd_valid  out  read data valid, one-cycle pulse
//   ready     out  array cleared, accesses accepted
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    output logic            ready
);

    // Index width of the storage array; addresses are range-checked before
    // being narrowed, so the truncation never aliases a live access.
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    // One extra bit so that NREG == 2**AW is representable without wrapping.
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);
    localparam logic [AW:0] LAST_W = (AW+1)'(NREG - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW:0]     clr_cnt;
    logic [AW:0]     clr_cnt_next;

    logic [XLEN-1:0] mem [NREG];

    logic            wr_ok_p0;
    logic            rd_fire_p0;
    logic [XLEN-1:0] rs1_pick_p0;
    logic [XLEN-1:0] rs2_pick_p0;

    // An address is usable when it exists and is not the hardwired zero.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Read-value priority: dead address -> 0, forwarded write -> wr_data,
    // otherwise the pre-write array contents.
    function automatic logic [XLEN-1:0] read_pick(input logic [AW-1:0]   a,
                                                  input logic [XLEN-1:0] stored,
                                                  input logic            fwd_ok);
        if (!addr_live(a)) begin
            return '0;
        end
        if ((BYPASS != 0) && fwd_ok && (wr_addr == a)) begin
            return wr_data;
        end
        return stored;
    endfunction

    assign ready      = (state == ST_RUN);
    assign wr_ok_p0   = ready && wr_en && addr_live(wr_addr);
    assign rd_fire_p0 = ready && rd_en;

    always_comb begin
        rs1_pick_p0 = read_pick(rs1_addr, mem[rs1_addr[IW-1:0]], wr_ok_p0);
        rs2_pick_p0 = read_pick(rs2_addr, mem[rs2_addr[IW-1:0]], wr_ok_p0);
    end

    // Control: state register and clear counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            ST_INIT: begin
                clr_cnt_next = clr_cnt + (AW+1)'(1);
                if (clr_cnt == LAST_W) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Array update: the clear sweep owns the write port during INIT, and
    // reset blocks both so a mid-sweep reset restarts cleanly from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT) begin
                mem[clr_cnt[IW-1:0]] <= '0;
            end else if (wr_ok_p0) begin
                mem[wr_addr[IW-1:0]] <= wr_data;
            end
        end
    end

    // Stage p0 -> p1: registered read data and valid strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            rs1_data <= '0;
            rs2_data <= '0;
            rd_valid <= 1'b0;
        end else if (rd_fire_p0) begin
            rs1_data <= rs1_pick_p0;
            rs2_data <= rs2_pick_p0;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//   Drives three register-file configurations from one shared stimulus:
//     d0: NREG=32, ZERO_REG=1, BYPASS=1
//     d1: NREG=32, ZERO_REG=0, BYPASS=0
//     d2: NREG=16, ZERO_REG=1, BYPASS=1
//   Each configuration has its own behavioural model (plain arrays and a
//   cycle count since reset release) that predicts outputs every cycle.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] r1  [3];
    logic [31:0] r2  [3];
    logic        vld [3];
    logic        rdy [3];

    regfile_param #(.XLEN(32), .NREG(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) d0 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs1_data(r1[0]), .rs2_data(r2[0]), .rd_valid(vld[0]), .ready(rdy[0]));

    regfile_param #(.XLEN(32), .NREG(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) d1 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs1_data(r1[1]), .rs2_data(r2[1]), .rd_valid(vld[1]), .ready(rdy[1]));

    regfile_param #(.XLEN(32), .NREG(16), .AW(5), .ZERO_REG(1), .BYPASS(1)) d2 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs1_data(r1[2]), .rs2_data(r2[2]), .rd_valid(vld[2]), .ready(rdy[2]));

    int n_cmp = 0;
    int n_mis = 0;

    // Model state per configuration
    logic [31:0] mm  [3][32];
    int          cnt [3];
    bit          run [3];
    logic [31:0] e1  [3];
    logic [31:0] e2  [3];
    logic        ev  [3];

    function automatic int nr(input int i);
        return (i == 2) ? 16 : 32;
    endfunction
    function automatic bit zr(input int i);
        return (i != 1);
    endfunction
    function automatic bit bp(input int i);
        return (i != 1);
    endfunction

    function automatic bit legal(input int i, input logic [4:0] a);
        return (int'(a) < nr(i)) && !(zr(i) && (a == 5'd0));
    endfunction

    function automatic logic [31:0] rv(input int i, input logic [4:0] a);
        if (!legal(i, a)) return 32'h0;
        if (bp(i) && wr_en && legal(i, wr_addr) && (wr_addr == a)) return wr_data;
        return mm[i][a];
    endfunction

    // Advance every model by one rising edge using the inputs present at it.
    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                cnt[i] = 0;
                run[i] = 1'b0;
                e1[i]  = 32'h0;
                e2[i]  = 32'h0;
                ev[i]  = 1'b0;
            end else if (!run[i]) begin
                cnt[i] = cnt[i] + 1;
                ev[i]  = 1'b0;
                if (cnt[i] == nr(i)) begin
                    run[i] = 1'b1;
                    for (int k = 0; k < 32; k++) mm[i][k] = 32'h0;
                end
            end else begin
                if (rd_en) begin
                    e1[i] = rv(i, rs1_addr);
                    e2[i] = rv(i, rs2_addr);
                    ev[i] = 1'b1;
                end else begin
                    ev[i] = 1'b0;
                end
                if (wr_en && legal(i, wr_addr)) mm[i][wr_addr] = wr_data;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d_rs1_data", i), r1[i], e1[i]);
            check($sformatf("d%0d_rs2_data", i), r2[i], e2[i]);
            check($sformatf("d%0d_rd_valid", i), {31'h0, vld[i]}, {31'h0, ev[i]});
            check($sformatf("d%0d_ready", i),    {31'h0, rdy[i]}, {31'h0, run[i]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic cyc(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic w, input logic [4:0] wa, input logic [31:0] wd);
        rd_en    = r;
        rs1_addr = a1;
        rs2_addr = a2;
        wr_en    = w;
        wr_addr  = wa;
        wr_data  = wd;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            run[i] = 1'b0;
            e1[i]  = 32'h0;
            e2[i]  = 32'h0;
            ev[i]  = 1'b0;
            for (int k = 0; k < 32; k++) mm[i][k] = 32'h0;
        end

        // Reset held for three cycles with requests active
        rst = 1'b0;
        for (int c = 0; c < 3; c++) cyc(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 32'hCAFE0000);
        check("reset_rd_valid", {31'h0, vld[0]}, 32'h0);
        check("reset_ready",    {31'h0, rdy[0]}, 32'h0);

        // Clear sweep; writes to x3 while INIT must be ignored
        rst = 1'b1;
        for (int c = 0; c < 32; c++) begin
            cyc(1'b1, 5'($urandom_range(31)), 5'($urandom_range(31)),
                c < 16, 5'd3, 32'h5);
            if (c == 30) check("ready_low_at_cycle_31", {31'h0, rdy[0]}, 32'h0);
            if (c == 15) check("d2_ready_after_16", {31'h0, rdy[2]}, 32'h1);
        end
        check("ready_high_after_32", {31'h0, rdy[0]}, 32'h1);

        // Every address reads zero after the sweep
        for (int a = 0; a < 32; a++) cyc(1'b1, 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'h0);
        cyc(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0);
        check("x3_init_write_dropped", r1[0], 32'h0);

        // Basic write then read, then idle hold
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd5,  32'hDEADBEEF);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'h12345678);
        cyc(1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'h0);
        check("basic_rs1", r1[0], 32'hDEADBEEF);
        check("basic_rs2", r2[0], 32'h12345678);
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        check("basic_hold_valid", {31'h0, vld[0]}, 32'h0);
        check("basic_hold_rs1", r1[0], 32'hDEADBEEF);

        // Zero register
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        check("zero_reg_rs1", r1[0], 32'h0);
        check("zero_reg_rs2", r2[0], 32'h0);
        check("no_zero_reg_rs1", r1[1], 32'hFFFFFFFF);

        // Bypass on a same-cycle write/read of x7
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11111111);
        cyc(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h22222222);
        check("bypass_on_rs1",  r1[0], 32'h22222222);
        check("bypass_on_rs2",  r2[0], 32'h22222222);
        check("bypass_off_rs1", r1[1], 32'h11111111);
        cyc(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
        check("bypass_off_later", r2[1], 32'h22222222);

        // Out-of-range address on the 16-entry configuration
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd20, 32'hAAAA5555);
        cyc(1'b1, 5'd20, 5'd20, 1'b0, 5'd0, 32'h0);
        check("oor_read_d2", r1[2], 32'h0);
        check("oor_read_d0", r1[0], 32'hAAAA5555);
        for (int a = 0; a < 16; a++) cyc(1'b1, 5'(a), 5'(a + 16), 1'b0, 5'd0, 32'h0);

        // Random traffic against the models
        for (int c = 0; c < 300; c++) begin
            cyc(1'($urandom_range(1)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
        end

        // Reset mid-operation during an active read
        for (int a = 1; a < 32; a++) cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'(a), $urandom | 32'h1);
        cyc(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        cyc(1'b1, 5'd5, 5'd6, 1'b1, 5'd9, 32'h77777777);
        check("midreset_valid", {31'h0, vld[0]}, 32'h0);
        check("midreset_rs1",   r1[0], 32'h0);
        check("midreset_ready", {31'h0, rdy[0]}, 32'h0);
        rst = 1'b1;
        for (int c = 0; c < 32; c++) cyc(1'b1, 5'd5, 5'd6, 1'b1, 5'd9, 32'h77777777);
        for (int a = 0; a < 32; a++) cyc(1'b1, 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'h0);
        cyc(1'b1, 5'd9, 5'd31, 1'b0, 5'd0, 32'h0);
        check("after_reset_x9", r1[0], 32'h0);
        check("after_reset_x31", r2[1], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
